// File: rtl/fc2_pkg.sv
// Shared types and constants for the FC2 RAM sequencer.
package fc2_pkg;

    localparam int unsigned FC2_DEPTH     = 16;
    localparam int unsigned FC2_WINDOW    = 5;
    localparam int unsigned FC2_N_NEURONS = 10;
    localparam int unsigned FC2_ADDR_W    = $clog2(FC2_DEPTH);
    localparam int unsigned FC2_NIDX_W    = $clog2(FC2_N_NEURONS);
    // Windows per neuron, rounded up so the tail window is counted.
    localparam int unsigned FC2_WIN_PER_NEURON = (FC2_DEPTH + FC2_WINDOW - 1) / FC2_WINDOW;

    typedef enum logic [2:0] {
        StIdle    = 3'd0,
        StLoad    = 3'd1,
        StIssue   = 3'd2,
        StPresent = 3'd3,
        StDone    = 3'd4
    } fc2_state_e;

endpackage

// File: rtl/fc2_window_ctr.sv
// Window offset / neuron index counter with first, last and final-window flags.
module fc2_window_ctr
    import fc2_pkg::*;
(
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_clear,
    input  logic                  i_advance,
    output logic [FC2_ADDR_W-1:0] o_offset,
    output logic [FC2_NIDX_W-1:0] o_neuron_idx,
    output logic                  o_first,
    output logic                  o_last,
    output logic                  o_final
);

    logic [FC2_ADDR_W-1:0] r_offset;
    logic [FC2_NIDX_W-1:0] r_neuron;
    // One extra bit so offset + WINDOW cannot wrap before the compare.
    logic [FC2_ADDR_W:0]   w_win_end;

    assign w_win_end    = {1'b0, r_offset} + (FC2_ADDR_W + 1)'(FC2_WINDOW);
    assign o_last       = (w_win_end >= (FC2_ADDR_W + 1)'(FC2_DEPTH));
    assign o_first      = (r_offset == '0);
    assign o_final      = o_last && (r_neuron == FC2_NIDX_W'(FC2_N_NEURONS - 1));
    assign o_offset     = r_offset;
    assign o_neuron_idx = r_neuron;

    // Step to the next window, wrapping into the next neuron; hold on the final window.
    always_ff @(posedge i_clk) begin
        if (i_rst || i_clear) begin
            r_offset <= '0;
            r_neuron <= '0;
        end else if (i_advance) begin
            if (!o_last) begin
                r_offset <= w_win_end[FC2_ADDR_W-1:0];
            end else if (!o_final) begin
                r_offset <= '0;
                r_neuron <= r_neuron + 1'b1;
            end
        end
    end

endmodule

// File: rtl/fc2_ram_sequencer.sv
// FC2 data RAM sequencer: loads the input vector, then replays it as 5-wide
// windows once per output neuron.
// Optional: define FC2_SEQ_STALL_CNT_EN to add the o_stall_cnt stall counter.
module fc2_ram_sequencer
    import fc2_pkg::*;
(
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_start,
    input  logic                  i_in_valid,
    output logic                  o_in_ready,
    output logic                  o_ram_we,
    output logic [FC2_ADDR_W-1:0] o_ram_waddr,
    output logic                  o_ram_re,
    output logic [FC2_ADDR_W-1:0] o_ram_raddr,
    output logic                  o_win_valid,
    input  logic                  i_win_ready,
    output logic                  o_win_first,
    output logic                  o_win_last,
    output logic [FC2_NIDX_W-1:0] o_neuron_idx,
    output logic                  o_layer_done,
`ifdef FC2_SEQ_STALL_CNT_EN
    output logic [15:0]           o_stall_cnt,
`endif
    output logic                  o_busy
);

    fc2_state_e            r_state;
    fc2_state_e            w_state_next;
    logic [FC2_ADDR_W-1:0] r_wr_cnt;
    logic                  r_ram_re;
    logic                  w_wr_inc;
    logic                  w_win_clear;
    logic                  w_win_adv;
    logic                  w_first;
    logic                  w_last;
    logic                  w_final;
    logic                  w_win_valid;

    fc2_window_ctr u_win_ctr (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_clear      (w_win_clear),
        .i_advance    (w_win_adv),
        .o_offset     (o_ram_raddr),
        .o_neuron_idx (o_neuron_idx),
        .o_first      (w_first),
        .o_last       (w_last),
        .o_final      (w_final)
    );

    // Next-state and counter control decode.
    always_comb begin
        w_state_next = r_state;
        w_wr_inc     = 1'b0;
        w_win_clear  = 1'b0;
        w_win_adv    = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (i_start) w_state_next = StLoad;
            end
            StLoad: begin
                if (i_in_valid) begin
                    w_wr_inc = 1'b1;
                    if (r_wr_cnt == FC2_ADDR_W'(FC2_DEPTH - 1)) begin
                        w_state_next = StIssue;
                        w_win_clear  = 1'b1;
                    end
                end
            end
            StIssue: begin
                w_state_next = StPresent;
            end
            StPresent: begin
                if (i_win_ready) begin
                    w_win_adv    = 1'b1;
                    w_state_next = w_final ? StDone : StIssue;
                end
            end
            StDone: begin
                // Park the window counter at zero for the idle period.
                w_win_clear  = 1'b1;
                w_state_next = StIdle;
            end
            default: begin
                w_state_next = StIdle;
            end
        endcase
    end

    // State, write counter and registered read strobe.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state  <= StIdle;
            r_wr_cnt <= '0;
            r_ram_re <= 1'b0;
        end else begin
            r_state  <= w_state_next;
            r_ram_re <= (w_state_next == StIssue);
            if (w_wr_inc) begin
                r_wr_cnt <= (r_wr_cnt == FC2_ADDR_W'(FC2_DEPTH - 1)) ? '0 : r_wr_cnt + 1'b1;
            end
        end
    end

`ifdef FC2_SEQ_STALL_CNT_EN
    logic [15:0] r_stall_cnt;

    // Saturating count of upstream starvation and downstream back-pressure cycles.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_stall_cnt <= '0;
        end else if (r_state == StIdle && i_start) begin
            r_stall_cnt <= '0;
        end else if (((r_state == StPresent) && !i_win_ready) ||
                     ((r_state == StLoad) && !i_in_valid)) begin
            if (r_stall_cnt != 16'hFFFF) r_stall_cnt <= r_stall_cnt + 16'd1;
        end
    end

    assign o_stall_cnt = r_stall_cnt;
`endif

    assign w_win_valid  = (r_state == StPresent);
    assign o_in_ready   = (r_state == StLoad);
    assign o_ram_we     = o_in_ready & i_in_valid;
    assign o_ram_waddr  = r_wr_cnt;
    assign o_ram_re     = r_ram_re;
    assign o_win_valid  = w_win_valid;
    assign o_win_first  = w_win_valid & w_first;
    assign o_win_last   = w_win_valid & w_last;
    assign o_layer_done = (r_state == StDone);
    assign o_busy       = (r_state != StIdle);

endmodule
